// File: rtl/pump_duty_scheduler_pkg.sv
// Shared definitions for the pump duty scheduler: state encodings, pump ids,
// level codes shared with the level controller, and the start-pump selection rule.
package pump_duty_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_START_DLY = 2'd1;
  localparam state_t ST_RUN       = 2'd2;
  localparam state_t ST_FAULT     = 2'd3;

  localparam logic PUMP_A = 1'b0;
  localparam logic PUMP_B = 1'b1;

  localparam logic [2:0] L0   = 3'd0;
  localparam logic [2:0] L25  = 3'd1;
  localparam logic [2:0] L50  = 3'd2;
  localparam logic [2:0] L75  = 3'd3;
  localparam logic [2:0] L100 = 3'd4;

  // Prefer the pump that did not run last; fall back to the other if it is locked out.
  function automatic logic pick_pump(input logic last_used, input logic [1:0] locked);
    logic pref;
    pref = ~last_used;
    if (!locked[pref]) return pref;
    return ~pref;
  endfunction

endpackage

// File: rtl/pump_duty_scheduler_tick.sv
// Free-running 1 s time base: emits a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/pump_duty_scheduler.sv
// Duty/standby pump scheduler: min off/on times, alternation on each start,
// dry-run lockout with failover, and a latched FAULT when both pumps are locked out.
module pump_duty_scheduler
  import pump_duty_scheduler_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int MIN_OFF_S     = 5,
  parameter int MIN_ON_S      = 3,
  parameter int DRY_TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pump_req,
  input  logic [2:0] lvl_sup,
  input  logic       fault_clr,
  output logic       pump_a_on,
  output logic       pump_b_on,
  output logic [1:0] pump_fault,
  output logic       fault,
  output logic [1:0] state_code
);

  localparam int OFF_W = $clog2(MIN_OFF_S + 1);
  localparam int RUN_W = $clog2(DRY_TIMEOUT_S + 1);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MIN_OFF_S);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DRY_TIMEOUT_S);
  localparam logic [RUN_W-1:0] ON_MIN  = RUN_W'(MIN_ON_S);

  logic tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic             last_used_reg, last_used_next;
  logic [1:0]       pump_fault_reg, pump_fault_next;
  logic [2:0]       lvl_ref_reg, lvl_ref_next;
  logic             progress_reg, progress_next;
  logic [OFF_W-1:0] off_cnt_reg;
  logic [RUN_W-1:0] run_cnt_reg;
  logic             run_entry;
  logic             both_off;

  assign both_off = !pump_a_on && !pump_b_on;

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    last_used_next  = last_used_reg;
    pump_fault_next = fault_clr ? 2'b00 : pump_fault_reg;
    lvl_ref_next    = lvl_ref_reg;
    progress_next   = progress_reg;
    run_entry       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pump_req) begin
          if (pump_fault_reg != 2'b11) begin
            state_next = ST_START_DLY;
            sel_next   = pick_pump(last_used_reg, pump_fault_reg);
          end else begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_START_DLY: begin
        if (!pump_req) begin
          state_next = ST_IDLE;
        end else if (off_cnt_reg >= OFF_MAX) begin
          state_next    = ST_RUN;
          lvl_ref_next  = lvl_sup;
          progress_next = 1'b0;
          run_entry     = 1'b1;
        end
      end
      ST_RUN: begin
        progress_next = progress_reg || (lvl_sup > lvl_ref_reg);
        // Dry-run detection outranks both a normal stop and a same-cycle clear.
        if (!progress_reg && run_cnt_reg >= RUN_MAX) begin
          pump_fault_next[sel_reg] = 1'b1;
          last_used_next           = sel_reg;
          state_next               = ST_IDLE;
        end else if (!pump_req && run_cnt_reg >= ON_MIN) begin
          last_used_next = sel_reg;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        if (fault_clr) state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= PUMP_A;
      last_used_reg  <= PUMP_B;
      pump_fault_reg <= 2'b00;
      lvl_ref_reg    <= L0;
      progress_reg   <= 1'b0;
      pump_a_on      <= 1'b0;
      pump_b_on      <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      last_used_reg  <= last_used_next;
      pump_fault_reg <= pump_fault_next;
      lvl_ref_reg    <= lvl_ref_next;
      progress_reg   <= progress_next;
      pump_a_on      <= (state_next == ST_RUN) && (sel_next == PUMP_A);
      pump_b_on      <= (state_next == ST_RUN) && (sel_next == PUMP_B);
      fault          <= (state_next == ST_FAULT);
    end
  end

  // Off-time accumulates across IDLE/START_DLY/FAULT; it restarts when a pump starts.
  always_ff @(posedge clk) begin
    if (rst || run_entry) begin
      off_cnt_reg <= '0;
    end else if (tick && both_off && off_cnt_reg < OFF_MAX) begin
      off_cnt_reg <= off_cnt_reg + OFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || run_entry) begin
      run_cnt_reg <= '0;
    end else if (tick && state_reg == ST_RUN && run_cnt_reg < RUN_MAX) begin
      run_cnt_reg <= run_cnt_reg + RUN_W'(1);
    end
  end

  assign state_code = state_reg;
  assign pump_fault = pump_fault_reg;

endmodule

// File: tb/tb_pump_duty_scheduler.sv
// Directed bench for pump_duty_scheduler with a scoreboard of expected values
// (TICK_DIV=4, MIN_OFF_S=2, MIN_ON_S=3, DRY_TIMEOUT_S=6; ticks land on edges 4, 8, 12, ...).
module tb_pump_duty_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       pump_req;
  logic [2:0] lvl_sup;
  logic       fault_clr;
  logic       pump_a_on;
  logic       pump_b_on;
  logic [1:0] pump_fault;
  logic       fault;
  logic [1:0] state_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int at;
  int any_on;

  string tag_q[$];
  int    exp_q[$];

  localparam int SEL_STATE = 0;
  localparam int SEL_A     = 1;
  localparam int SEL_B     = 2;

  pump_duty_scheduler #(
    .TICK_DIV(4), .MIN_OFF_S(2), .MIN_ON_S(3), .DRY_TIMEOUT_S(6)
  ) dut (
    .clk(clk), .rst(rst), .pump_req(pump_req), .lvl_sup(lvl_sup), .fault_clr(fault_clr),
    .pump_a_on(pump_a_on), .pump_b_on(pump_b_on), .pump_fault(pump_fault),
    .fault(fault), .state_code(state_code)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input int obs);
    string t;
    int e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
      $display("cyc=%0d %s observed=%0d expected=%0d", cyc, t, obs, e);
    end
  endtask

  // One clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    total++;
    assert (!(pump_a_on && pump_b_on)) else begin
      bad++;
      $error("FAIL both_on cyc=%0d observed=11 expected=not 11", cyc);
    end
  endtask

  function automatic int cur(input int which);
    case (which)
      SEL_STATE: return int'(state_code);
      SEL_A:     return int'(pump_a_on);
      SEL_B:     return int'(pump_b_on);
      default:   return int'(fault);
    endcase
  endfunction

  // Returns the cycle at which the selected output reached val, or -1 on timeout.
  task automatic wait_sig(input int which, input int val, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cur(which) == val) begin
        when = cyc;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; pump_req = 1'b0; lvl_sup = 3'd0; fault_clr = 1'b0;
    repeat (3) step();
    expect_val("reset_outputs", 0);
    check(int'({pump_a_on, pump_b_on, pump_fault, fault, state_code}));

    // 1: first start waits MIN_OFF_S from reset, then A runs
    rst = 1'b0; pump_req = 1'b1; lvl_sup = 3'd1; cyc = 0;
    expect_val("t1_start_dly", 1);
    step();
    check(int'(state_code));
    expect_val("t1_run_at", 9);
    wait_sig(SEL_STATE, 2, 40, at);
    check(at);
    expect_val("t1_a_on", 1);
    check(int'(pump_a_on));
    expect_val("t1_b_off", 0);
    check(int'(pump_b_on));

    // 2: early request drop honoured only at run_cnt=3; next start alternates to B
    repeat (3) step();
    lvl_sup = 3'd2; pump_req = 1'b0;
    expect_val("t2_a_off_at", 21);
    wait_sig(SEL_A, 0, 40, at);
    check(at);
    expect_val("t2_idle", 0);
    check(int'(state_code));
    pump_req = 1'b1;
    expect_val("t2_b_on_at", 29);
    wait_sig(SEL_B, 1, 40, at);
    check(at);
    expect_val("t2_a_stays_off", 0);
    check(int'(pump_a_on));

    // 3: stop B, start A with flat level -> dry fault on A, failover to B
    pump_req = 1'b0;
    expect_val("t3_b_off_at", 41);
    wait_sig(SEL_B, 0, 40, at);
    check(at);
    pump_req = 1'b1;
    expect_val("t3_a_on_at", 49);
    wait_sig(SEL_A, 1, 40, at);
    check(at);
    expect_val("t3_a_dry_off_at", 73);
    wait_sig(SEL_A, 0, 60, at);
    check(at);
    expect_val("t3_pump_fault", 1);
    check(int'(pump_fault));
    expect_val("t3_b_failover_at", 81);
    wait_sig(SEL_B, 1, 40, at);
    check(at);

    // 4: B also runs dry -> latched FAULT; fault_clr recovers and A starts
    expect_val("t4_fault_state_at", 106);
    wait_sig(SEL_STATE, 3, 60, at);
    check(at);
    expect_val("t4_pump_fault", 3);
    check(int'(pump_fault));
    expect_val("t4_fault_flag", 1);
    check(int'(fault));
    any_on = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pump_a_on || pump_b_on) any_on = 1;
    end
    expect_val("t4_no_start_in_fault", 0);
    check(any_on);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    expect_val("t4_clr_state", 0);
    check(int'(state_code));
    expect_val("t4_clr_fault_flag", 0);
    check(int'(fault));
    expect_val("t4_clr_pump_fault", 0);
    check(int'(pump_fault));
    expect_val("t4_a_on_at", 129);
    wait_sig(SEL_A, 1, 40, at);
    check(at);

    // 5: dry detection, fault_clr and request drop all at run_cnt=6 -> fault wins
    repeat (23) step();
    expect_val("t5_still_run", 2);
    check(int'(state_code));
    fault_clr = 1'b1; pump_req = 1'b0;
    step();
    fault_clr = 1'b0;
    expect_val("t5_pump_fault", 1);
    check(int'(pump_fault));
    expect_val("t5_idle", 0);
    check(int'(state_code));
    expect_val("t5_a_off", 0);
    check(int'(pump_a_on));

    // 6: B starts; fault_clr while running leaves B on; reset mid-run restarts everything
    pump_req = 1'b1;
    expect_val("t6_b_on_at", 161);
    wait_sig(SEL_B, 1, 40, at);
    check(at);
    repeat (2) step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    expect_val("t6_clr_in_run", 0);
    check(int'(pump_fault));
    expect_val("t6_b_undisturbed", 1);
    check(int'(pump_b_on));
    step();
    rst = 1'b1;
    step();
    expect_val("t6_reset_outputs", 0);
    check(int'({pump_a_on, pump_b_on, pump_fault, fault, state_code}));
    rst = 1'b0; lvl_sup = 3'd1; cyc = 0;
    expect_val("t6_restart_a_at", 9);
    wait_sig(SEL_A, 1, 40, at);
    check(at);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
